// File: rtl/boolean_sample_controller_pkg.sv
// Shared definitions for the Boolean sampling controller.
// Holds the problem sizing, the LFSR seed, the FSM state encodings and
// the helper that folds a raw LFSR slice into a legal variable index.
package boolean_sample_controller_pkg;

  localparam int NUMBER_OF_BOOLEAN_VARIABLES        = 8;
  localparam int BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 3;
  localparam int COST_WIDTH                         = 8;
  localparam logic [15:0] LFSR_SEED                 = 16'hACE1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PROPOSE   = 3'd1;
  localparam logic [2:0] ST_EVAL_REQ  = 3'd2;
  localparam logic [2:0] ST_EVAL_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  // Because N <= 2^W < 2N, a single conditional subtraction of N always
  // lands the raw slice inside 0..N-1.
  function automatic logic [BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX-1:0] fold_index(
    input logic [BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX-1:0] raw
  );
    int unsigned r;
    r = int'(raw);
    if (r >= NUMBER_OF_BOOLEAN_VARIABLES) r = r - NUMBER_OF_BOOLEAN_VARIABLES;
    return BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX'(r);
  endfunction

endpackage

// File: rtl/boolean_sample_controller_lfsr16.sv
// 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset (loads SEED)
//   shift_en    : advance one step at the next clock edge
//   value       : current register contents
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift_en,
  output logic [15:0] value
);

  logic feedback;

  // Taps 16,14,13,11 map to bits 15,13,12,10 of a left-shifting register.
  assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else if (shift_en) begin
      value <= {value[14:0], feedback};
    end
  end

endmodule

// File: rtl/boolean_sample_controller.sv
// Boolean sampling controller for the MCMC constraint solver.
// Owns the committed Boolean assignment, picks a flip index from an LFSR,
// drives the external proposer, hands the proposal to the cost evaluator and
// makes a Metropolis-style accept/reject decision on the returned delta.
// Ports:
//   in_clk / in_reset_n                : clock, async active-low reset
//   in_start, in_initial_assignment_boolean, in_iterations : run launch
//   out_current_assignment_boolean, out_variable_to_be_changed_index,
//   out_propose_enable, in_new_assignment_boolean         : proposer link
//   out_eval_valid, in_eval_ready, out_proposed_assignment_boolean : to evaluator
//   in_result_valid, in_delta_cost     : evaluator result
//   out_busy, out_done, out_accept_count : run status
//   out_debug_state, out_debug_lfsr    : FSM state and LFSR contents
module boolean_sample_controller
  import boolean_sample_controller_pkg::*;
(
  input  logic                                           in_clk,
  input  logic                                           in_reset_n,
  input  logic                                           in_start,
  input  logic [0:NUMBER_OF_BOOLEAN_VARIABLES-1]         in_initial_assignment_boolean,
  input  logic [15:0]                                    in_iterations,
  output logic [0:NUMBER_OF_BOOLEAN_VARIABLES-1]         out_current_assignment_boolean,
  output logic [BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX-1:0] out_variable_to_be_changed_index,
  output logic                                           out_propose_enable,
  input  logic [0:NUMBER_OF_BOOLEAN_VARIABLES-1]         in_new_assignment_boolean,
  output logic                                           out_eval_valid,
  input  logic                                           in_eval_ready,
  output logic [0:NUMBER_OF_BOOLEAN_VARIABLES-1]         out_proposed_assignment_boolean,
  input  logic                                           in_result_valid,
  input  logic signed [COST_WIDTH-1:0]                   in_delta_cost,
  output logic                                           out_busy,
  output logic                                           out_done,
  output logic [15:0]                                    out_accept_count,
  output logic [2:0]                                     out_debug_state,
  output logic [15:0]                                    out_debug_lfsr
);

  logic [2:0]  state;
  logic [15:0] remaining;
  logic [15:0] lfsr_value;
  logic        lfsr_shift;
  logic        decide;
  logic        accept;

  // Handshake: out_eval_valid is a flop raised at the end of PROPOSE and
  // cleared only on the cycle where it is high together with in_eval_ready;
  // the proposal register is untouched while it is high. in_result_valid is
  // a single-cycle pulse and is only consumed in EVAL_WAIT.
  assign decide     = (state == ST_EVAL_WAIT) && in_result_valid;
  assign lfsr_shift = (state == ST_PROPOSE) || decide;

  // Uses the pre-shift LFSR value of the decide cycle. A positive delta is
  // compared against a 7-bit uniform draw, so +127 can never be accepted.
  assign accept = in_delta_cost[COST_WIDTH-1] || (in_delta_cost == '0) ||
                  ({1'b0, lfsr_value[COST_WIDTH-2:0]} > $unsigned(in_delta_cost));

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk      (in_clk),
    .rst_n    (in_reset_n),
    .shift_en (lfsr_shift),
    .value    (lfsr_value)
  );

  // Index is only meaningful while proposing; zero elsewhere keeps the
  // proposer input quiet and matches the reset value.
  assign out_variable_to_be_changed_index =
    (state == ST_PROPOSE) ? fold_index(lfsr_value[BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX-1:0]) : '0;
  assign out_propose_enable = (state == ST_PROPOSE);
  assign out_busy           = (state != ST_IDLE);
  assign out_done           = (state == ST_DONE);
  assign out_debug_state    = state;
  assign out_debug_lfsr     = lfsr_value;

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state                           <= ST_IDLE;
      remaining                       <= '0;
      out_accept_count                <= '0;
      out_current_assignment_boolean  <= '0;
      out_proposed_assignment_boolean <= '0;
      out_eval_valid                  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_start) begin
            out_current_assignment_boolean <= in_initial_assignment_boolean;
            remaining                      <= in_iterations;
            out_accept_count               <= '0;
            state <= (in_iterations == 16'd0) ? ST_DONE : ST_PROPOSE;
          end
        end
        ST_PROPOSE: begin
          out_proposed_assignment_boolean <= in_new_assignment_boolean;
          out_eval_valid                  <= 1'b1;
          state                           <= ST_EVAL_REQ;
        end
        ST_EVAL_REQ: begin
          if (out_eval_valid && in_eval_ready) begin
            out_eval_valid <= 1'b0;
            state          <= ST_EVAL_WAIT;
          end
        end
        ST_EVAL_WAIT: begin
          if (decide) begin
            if (accept) begin
              out_current_assignment_boolean <= out_proposed_assignment_boolean;
              if (out_accept_count != 16'hFFFF) out_accept_count <= out_accept_count + 16'd1;
            end
            remaining <= remaining - 16'd1;
            state     <= (remaining == 16'd1) ? ST_DONE : ST_PROPOSE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
